reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: clocks all stage resets stay asserted after reset deasserts; legal range 1..65535.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255: maximum clocks to wait for a stage acknowledge; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1 bit: single system clock, rising-edge only.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, already synchronized to clk.
REQ-005 SHALL have port soft_reset_req, input, 1 bit: single-cycle request to rerun the full sequence.
REQ-006 SHALL have port stage_ack, input, 3 bits: bit n high means stage n has come out of reset.
REQ-007 SHALL have port rst_out, output, 3 bits, registered: active-high reset to stage n.
REQ-008 SHALL have port seq_done, output, 1 bit, registered: all stages released and acknowledged.
REQ-009 SHALL have port timeout_err, output, 1 bit, registered, sticky: at least one stage acknowledge timed out.

Function
REQ-010 SHALL implement FSM states HOLD, REL0, REL1, REL2, DONE.
REQ-011 HOLD behaviour:
- rst_out=3'b111.
- Counter increments on each edge.
- At the edge where the counter reaches HOLD_CYCLES-1: go to REL0 and clear rst_out[0] at that same edge.
- Result: rst_out[0] falls on the HOLD_CYCLES-th edge at which reset is sampled low.
REQ-012 RELn behaviour (ack counter cleared on entry):
- Edge with stage_ack[n]=1 and n<2: go to REL(n+1) and clear rst_out[n+1] at that edge.
- Edge with stage_ack[2]=1 in REL2: go to DONE and set seq_done=1 at that edge.
REQ-013 In RELn, if stage_ack[n] is still low at the ACK_TIMEOUT-th edge: set timeout_err=1 and advance exactly as REQ-012.
REQ-014 If stage_ack[n] rises on the same edge the timeout expires, the acknowledge SHALL win and timeout_err SHALL NOT be set.
REQ-015 In RELn, stage_ack bits other than bit n SHALL be ignored.
REQ-016 Once released, a stage's rst_out bit SHALL stay low until reset or a soft reset.
REQ-017 In DONE, soft_reset_req=1 at an edge SHALL, at that edge:
- set rst_out=3'b111 and seq_done=0;
- clear the hold counter and enter HOLD.
- timeout_err keeps its value.
REQ-018 soft_reset_req SHALL be ignored in HOLD and RELn; a request during an active sequence does not restart it.
REQ-019 Counters SHALL be 16 bits wide, never wrap, and be cleared on every state entry.
REQ-020 Outputs SHALL change only on rising clk edges, with no combinational path from any input to any output.

Reset
REQ-021 While reset=1 at an edge: state=HOLD, counters=0, rst_out=3'b111, seq_done=0, timeout_err=0.
REQ-022 reset SHALL take priority over every other input, including soft_reset_req and stage_ack.
REQ-023 reset asserted mid-sequence or in DONE SHALL return all outputs to REQ-021 values at that edge, and the full sequence reruns after deassertion.

Verification
REQ-024 Nominal run, HOLD_CYCLES=4, 20 ns clk, reset low from edge 1:
- rst_out[0] falls at edge 4.
- stage_ack[0] high at edge 7 -> rst_out[1] falls at edge 7.
- acks for stages 1 and 2 follow -> seq_done=1 at the stage-2 ack edge, timeout_err=0.
REQ-025 Timeout, ACK_TIMEOUT=8, stage_ack[1] held low -> rst_out[2] falls and timeout_err=1 at the 8th edge in REL1; timeout_err remains 1 after DONE.
REQ-026 Simultaneous events:
- stage_ack[0] rises exactly on the ACK_TIMEOUT-th edge -> advance with timeout_err=0.
- stage_ack[2] asserted early during REL0 -> ignored, no premature seq_done.
REQ-027 Soft reset:
- pulse in DONE -> rst_out=3'b111 and seq_done=0 at the next edge, then the full sequence reruns with timeout_err preserved.
- pulse during REL1 -> no effect.
REQ-028 Reset mid-operation: reset=1 for one edge while in REL1 -> rst_out=3'b111, seq_done=0, timeout_err=0 at that edge; after deassertion rst_out[0] falls again HOLD_CYCLES edges later.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: holds three stage resets for a fixed time, then releases
// them one at a time, each waiting for that stage's acknowledge or a timeout.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       soft_reset_req,
    input  logic [2:0] stage_ack,
    output logic [2:0] rst_out,
    output logic       seq_done,
    output logic       timeout_err
);

    typedef enum logic [2:0] {
        HOLD,
        REL0,
        REL1,
        REL2,
        DONE
    } state_t;

    // Terminal counts; a counter never runs past these, so it cannot wrap.
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] ACK_LAST  = 16'(ACK_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  rst_nxt;
    logic        done_nxt;
    logic        terr_nxt;
    logic        ack_sel;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rst_nxt   = rst_out;
        done_nxt  = seq_done;
        terr_nxt  = timeout_err;
        ack_sel   = 1'b0;

        case (state)
            HOLD: begin
                rst_nxt = 3'b111;
                if (cnt == HOLD_LAST) begin
                    state_nxt = REL0;
                    cnt_nxt   = '0;
                    rst_nxt   = 3'b110;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            REL0, REL1, REL2: begin
                // Only the acknowledge of the stage just released is looked at.
                case (state)
                    REL0:    ack_sel = stage_ack[0];
                    REL1:    ack_sel = stage_ack[1];
                    default: ack_sel = stage_ack[2];
                endcase
                if (ack_sel || (cnt == ACK_LAST)) begin
                    if (!ack_sel) terr_nxt = 1'b1;
                    cnt_nxt = '0;
                    case (state)
                        REL0: begin
                            state_nxt  = REL1;
                            rst_nxt[1] = 1'b0;
                        end
                        REL1: begin
                            state_nxt  = REL2;
                            rst_nxt[2] = 1'b0;
                        end
                        default: begin
                            state_nxt = DONE;
                            done_nxt  = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            DONE: begin
                if (soft_reset_req) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    rst_nxt   = 3'b111;
                    done_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt = HOLD;
                cnt_nxt   = '0;
                rst_nxt   = 3'b111;
                done_nxt  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            cnt         <= '0;
            rst_out     <= 3'b111;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rst_out     <= rst_nxt;
            seq_done    <= done_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with HOLD_CYCLES=4 and ACK_TIMEOUT=8.
module tb_reset_sequencer;

    localparam int HOLD = 4;
    localparam int TMO  = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       soft_reset_req;
    logic [2:0] stage_ack;
    logic [2:0] rst_out;
    logic       seq_done;
    logic       timeout_err;

    int vectors = 0;
    int errors  = 0;

    reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .soft_reset_req(soft_reset_req),
        .stage_ack     (stage_ack),
        .rst_out       (rst_out),
        .seq_done      (seq_done),
        .timeout_err   (timeout_err)
    );

    always #10 clk = ~clk;

    // Observed vector is {rst_out, seq_done, timeout_err}, sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; soft_reset_req = 1'b0; stage_ack = 3'b000;
        tick();
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_state: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b11100);
        end
    endtask

    // HOLD_CYCLES edges of hold; rst_out[0] must drop on the last one.
    task automatic test_hold_phase(input logic terr, input string tag);
        logic [4:0] exp;
        for (int e = 1; e <= HOLD; e++) begin
            tick();
            exp = (e == HOLD) ? {4'b1100, terr} : {4'b1110, terr};
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== exp) begin
                errors++;
                $display("FAIL %s edge %0d: observed %b, expected %b", tag, e, {rst_out, seq_done, timeout_err}, exp);
            end
        end
    endtask

    task automatic test_nominal();
        reset = 1'b0;
        test_hold_phase(1'b0, "nominal_hold");
        for (int e = 5; e <= 6; e++) begin
            tick();
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== 5'b11000) begin
                errors++;
                $display("FAIL rel0_wait edge %0d: observed %b, expected %b", e, {rst_out, seq_done, timeout_err}, 5'b11000);
            end
        end
        stage_ack = 3'b001;
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b10000) begin
            errors++;
            $display("FAIL rel1_entry_edge7: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b10000);
        end
        stage_ack = 3'b011;
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b00000) begin
            errors++;
            $display("FAIL rel2_entry: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b00000);
        end
        stage_ack = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== 5'b00010) begin
                errors++;
                $display("FAIL nominal_done %0d: observed %b, expected %b", i, {rst_out, seq_done, timeout_err}, 5'b00010);
            end
        end
    endtask

    task automatic test_soft_done();
        soft_reset_req = 1'b1; stage_ack = 3'b000;
        tick();
        soft_reset_req = 1'b0;
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b11100) begin
            errors++;
            $display("FAIL soft_in_done: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b11100);
        end
        test_hold_phase(1'b0, "soft_rerun_hold");
    endtask

    task automatic test_timeout();
        stage_ack = 3'b001;
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b10000) begin
            errors++;
            $display("FAIL tmo_rel1_entry: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b10000);
        end
        // Bits 0 and 2 high but bit 1 low: REL1 must still time out.
        stage_ack = 3'b101;
        for (int e = 1; e < TMO; e++) begin
            tick();
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== 5'b10000) begin
                errors++;
                $display("FAIL rel1_wait edge %0d: observed %b, expected %b", e, {rst_out, seq_done, timeout_err}, 5'b10000);
            end
        end
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b00001) begin
            errors++;
            $display("FAIL rel1_timeout: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b00001);
        end
        stage_ack = 3'b100;
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b00011) begin
            errors++;
            $display("FAIL done_after_timeout: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b00011);
        end
    endtask

    task automatic test_soft_preserve();
        soft_reset_req = 1'b1; stage_ack = 3'b000;
        tick();
        soft_reset_req = 1'b0;
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b11101) begin
            errors++;
            $display("FAIL soft_keeps_terr: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b11101);
        end
        test_hold_phase(1'b1, "sticky_hold");
        stage_ack = 3'b001; tick();
        stage_ack = 3'b011; tick();
        stage_ack = 3'b111; tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b00011) begin
            errors++;
            $display("FAIL rerun_done_sticky: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b00011);
        end
    endtask

    task automatic test_soft_in_rel1();
        soft_reset_req = 1'b1; stage_ack = 3'b000;
        tick();
        soft_reset_req = 1'b0;
        test_hold_phase(1'b1, "rel1_soft_hold");
        stage_ack = 3'b001;
        tick();
        stage_ack = 3'b000; soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== 5'b10001) begin
                errors++;
                $display("FAIL soft_ignored_rel1 %0d: observed %b, expected %b", i, {rst_out, seq_done, timeout_err}, 5'b10001);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1; soft_reset_req = 1'b1; stage_ack = 3'b111;
        tick();
        reset = 1'b0; soft_reset_req = 1'b0; stage_ack = 3'b000;
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_mid_rel1: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b11100);
        end
        test_hold_phase(1'b0, "post_reset_hold");
    endtask

    task automatic test_ack_on_timeout();
        // Early stage-2 acknowledge during REL0 must be ignored.
        stage_ack = 3'b100;
        for (int e = 1; e < TMO; e++) begin
            tick();
            vectors++;
            if ({rst_out, seq_done, timeout_err} !== 5'b11000) begin
                errors++;
                $display("FAIL early_ack2_ignored edge %0d: observed %b, expected %b", e, {rst_out, seq_done, timeout_err}, 5'b11000);
            end
        end
        stage_ack = 3'b101;
        tick();
        vectors++;
        if ({rst_out, seq_done, timeout_err} !== 5'b10000) begin
            errors++;
            $display("FAIL ack_wins_timeout: observed %b, expected %b", {rst_out, seq_done, timeout_err}, 5'b10000);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_soft_done();
        test_timeout();
        test_soft_preserve();
        test_soft_in_rel1();
        test_reset_mid();
        test_ack_on_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
